// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage: fetch FSM states
// and the {pc, instr} entry carried from imem to decode.
package if_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam int              ILEN     = 32;

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO of fetch entries with push/pop/flush and a registered
// head: an entry pushed on one edge is visible at dout after that edge.
module if_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = if_entry_t,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  entry_t      din,
  input  logic        pop,
  input  logic        flush,
  output entry_t      dout,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: next-PC mux around an external PC register, a
// single-outstanding imem request FSM and a decode-side FIFO.
// Optional perf counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_unit #(
  parameter int              XLEN       = if_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(if_pkg::RESET_PC),
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [XLEN-1:0]         pc_i,
  output logic [XLEN-1:0]         pc_next_o,
  input  logic                    redirect_i,
  input  logic [XLEN-1:0]         redirect_pc_i,
  output logic                    imem_req_o,
  output logic [XLEN-1:0]         imem_addr_o,
  input  logic                    imem_gnt_i,
  input  logic                    imem_rvalid_i,
  input  logic [if_pkg::ILEN-1:0] imem_rdata_i,
  output logic                    if_valid_o,
  output logic [if_pkg::ILEN-1:0] if_instr_o,
  output logic [XLEN-1:0]         if_pc_o,
  input  logic                    id_ready_i
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]             perf_fetched_o,
  output logic [31:0]             perf_stall_o
`endif
);

  import if_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  fetch_state_t    state;
  logic            outstanding;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            space;
  logic            grant;
  logic            push;
  logic            pop;
  entry_t          push_entry;
  entry_t          head;

  // Outstanding response reserves a slot, so a full FIFO never drops data.
  assign space       = ~fifo_full & ((fifo_count + CW'(outstanding)) < CW'(FIFO_DEPTH));
  assign imem_req_o  = (state == REQ) & space & ~redirect_i;
  assign imem_addr_o = pc_i;
  assign grant       = imem_req_o & imem_gnt_i;
  assign push        = (state == WAIT) & imem_rvalid_i & ~redirect_i;
  assign pop         = if_valid_o & id_ready_i;
  assign push_entry  = '{pc: pc_q, instr: imem_rdata_i};

  assign if_valid_o  = ~fifo_empty;
  assign if_pc_o     = head.pc;
  assign if_instr_o  = head.instr;

  // NOTE: default assignment first so no path leaves pc_next_o unassigned (no latch).
  always_comb begin
    pc_next_o = pc_i;
    if (state == BOOT)   pc_next_o = RESET_PC;
    else if (redirect_i) pc_next_o = redirect_pc_i & ~XLEN'(3);
    else if (grant)      pc_next_o = pc_i + XLEN'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      outstanding <= 1'b0;
      pc_q        <= RESET_PC;
    end else begin
      case (state)
        BOOT: state <= REQ;
        REQ: begin
          if (grant) begin
            state       <= WAIT;
            outstanding <= 1'b1;
            pc_q        <= pc_i;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            state       <= REQ;
            outstanding <= 1'b0;
          end else if (redirect_i) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The stale response is consumed here and never pushed.
          if (imem_rvalid_i) begin
            state       <= REQ;
            outstanding <= 1'b0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  if_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .flush (redirect_i),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (push && perf_fetched_o != '1)
        perf_fetched_o <= perf_fetched_o + 32'd1;
      if (imem_req_o && !imem_gnt_i && perf_stall_o != '1)
        perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: queue-based reference model of the
// decode stream, table-driven boot sequence, directed corners, random traffic.
module tb_if_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_i;
  logic [31:0] pc_next_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic        id_ready_i;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_stall_o;
`endif

  if_fetch_unit #(
    .XLEN       (32),
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_i          (pc_i),
    .pc_next_o     (pc_next_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .id_ready_i    (id_ready_i)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched_o (perf_fetched_o),
    .perf_stall_o   (perf_stall_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External PC register: no enable, holds only because the DUT drives pc_i back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_i <= RPC;
    else        pc_i <= pc_next_o;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    bit          ready;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
    logic [31:0] nxt;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // stimulus controls
  int          gnt_mode = 1;   // 0 low, 1 high, 2 random
  int          rdy_mode = 1;
  int          lat_cfg = 1;    // 0 random 1..3
  int          redir_rate = 0;
  bit          redir = 0;
  logic [31:0] redir_tgt = 32'h0;

  // memory side
  bit          mem_out = 0;
  int          mem_lat = 0;
  logic [31:0] mem_addr = 32'h0;

  // reference model
  ent_t        q[$];
  bit          boot = 1;
  bit          mdl_out = 0;
  bit          discard = 0;
  logic [31:0] exp_fetch = RPC;
  logic [31:0] out_pc = 32'h0;
  int          n_push = 0;

  // observations
  int          grant_cnt = 0;
  logic [31:0] last_gnt_addr = 32'h0;
  logic [31:0] last_gnt_next = 32'h0;
  int          n_pops = 0;
  logic [31:0] popped_q[$];
  bit          snap_req, snap_valid;
  logic [31:0] snap_addr, snap_pc, snap_next;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F0F;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pick(int mode);
    return (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
  endfunction

  task automatic drive();
    imem_rvalid_i = mem_out && (mem_lat == 0);
    imem_rdata_i  = imem_rvalid_i ? instr_of(mem_addr) : 32'hDEAD_BEEF;
    imem_gnt_i    = pick(gnt_mode) && !mem_out;
    id_ready_i    = pick(rdy_mode);
    redirect_i    = redir || (redir_rate != 0 && $urandom_range(0, redir_rate - 1) == 0);
    redirect_pc_i = redir ? redir_tgt : $urandom;
  endtask

  task automatic cycle();
    bit          exp_req, rv, pop;
    logic [31:0] exp_next;
    drive();
    @(negedge clk);
    snap_req = imem_req_o; snap_addr = imem_addr_o; snap_valid = if_valid_o;
    snap_pc = if_pc_o; snap_next = pc_next_o;
    if (!rst_n) begin
      check("rst_valid", if_valid_o, 0);
      check("rst_req", imem_req_o, 0);
      check("rst_pc_next", pc_next_o, RPC);
      q.delete(); mdl_out = 0; discard = 0; boot = 1; n_push = 0; exp_fetch = RPC;
    end else begin
      exp_req  = !boot && !mdl_out && (q.size() < DEPTH) && !redirect_i;
      rv       = imem_rvalid_i && mdl_out;
      exp_next = boot ? RPC
               : redirect_i ? (redirect_pc_i & ~32'd3)
               : (exp_req && imem_gnt_i) ? exp_fetch + 32'd4 : exp_fetch;
      check("if_valid", if_valid_o, q.size() != 0);
      if (q.size() != 0) begin
        check("if_pc", if_pc_o, q[0].pc);
        check("if_instr", if_instr_o, q[0].instr);
      end
      check("imem_req", imem_req_o, exp_req);
      check("pc_next", pc_next_o, exp_next);
      if (exp_req) check("imem_addr", imem_addr_o, exp_fetch);
      if (if_valid_o && id_ready_i) begin
        n_pops++;
        popped_q.push_back(if_pc_o);
      end
      if (imem_req_o && imem_gnt_i) begin
        grant_cnt++;
        last_gnt_addr = imem_addr_o;
        last_gnt_next = pc_next_o;
      end
      pop = (q.size() != 0) && id_ready_i;
      if (redirect_i) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (rv && !discard) begin
          q.push_back('{pc: out_pc, instr: instr_of(out_pc)});
          n_push++;
        end
      end
      if (rv) begin mdl_out = 0; discard = 0; end
      else if (redirect_i && mdl_out) discard = 1;
      if (exp_req && imem_gnt_i) begin mdl_out = 1; out_pc = exp_fetch; end
      exp_fetch = exp_next;
      boot = 0;
    end
    if (imem_rvalid_i) mem_out = 0;
    else if (mem_out) mem_lat--;
    if (imem_req_o && imem_gnt_i) begin
      mem_out  = 1;
      mem_addr = imem_addr_o;
      mem_lat  = ((lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg) - 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(string name, output bit ok);
    int g0 = grant_cnt;
    for (int i = 0; i < 30 && grant_cnt == g0; i++) cycle();
    ok = (grant_cnt != g0);
    check(name, ok, 1);
  endtask

  vec_t tbl[8];

  initial begin
    bit ok;
    int p0;
    logic [31:0] s0;

    tbl[0] = '{1, 0, 32'h0, 0, 32'h0, 32'h0};
    tbl[1] = '{1, 1, 32'h0, 0, 32'h0, 32'h4};
    tbl[2] = '{1, 0, 32'h0, 0, 32'h0, 32'h4};
    tbl[3] = '{0, 1, 32'h4, 1, 32'h0, 32'h8};
    tbl[4] = '{1, 0, 32'h0, 1, 32'h0, 32'h8};
    tbl[5] = '{1, 1, 32'h8, 1, 32'h4, 32'hC};
    tbl[6] = '{1, 0, 32'h0, 0, 32'h0, 32'hC};
    tbl[7] = '{1, 1, 32'hC, 1, 32'h8, 32'h10};

    rst_n = 1'b0;
    #1;
    check("t0_async_valid", if_valid_o, 0);
    check("t0_async_req", imem_req_o, 0);
    cycle();
    cycle();
    rst_n = 1'b1;

    // 1: boot stream with gnt tied high and one-cycle response latency
    for (int i = 0; i < 8; i++) begin
      rdy_mode = int'(tbl[i].ready);
      cycle();
      check($sformatf("t1_req[%0d]", i), snap_req, tbl[i].req);
      if (tbl[i].req) check($sformatf("t1_addr[%0d]", i), snap_addr, tbl[i].addr);
      check($sformatf("t1_valid[%0d]", i), snap_valid, tbl[i].valid);
      if (tbl[i].valid) check($sformatf("t1_pc[%0d]", i), snap_pc, tbl[i].pc);
      check($sformatf("t1_next[%0d]", i), snap_next, tbl[i].nxt);
    end

    // 2: decode stalls; FIFO fills to depth, requests stop, PC held
    rdy_mode = 0;
    repeat (6) cycle();
    check("t2_req_blocked", imem_req_o, 0);
    check("t2_pc_hold", pc_next_o, pc_i);
    check("t2_valid", if_valid_o, 1);
    gnt_mode = 0;
    rdy_mode = 1;
    p0 = n_pops;
    repeat (8) cycle();
    check("t2_buffered", n_pops - p0, DEPTH);

    // 3: redirect while waiting on a response
    gnt_mode = 1; lat_cfg = 3; rdy_mode = 0;
    for (int i = 0; i < 40 && !(q.size() >= 1 && mdl_out && !discard && mem_lat >= 1); i++) cycle();
    check("t3_reach_wait", q.size() >= 1 && mdl_out && mem_lat >= 1, 1);
    popped_q.delete();
    redir = 1; redir_tgt = 32'h0000_0103;
    cycle();
    redir = 0; rdy_mode = 1;
    check("t3_flushed", if_valid_o, 0);
    wait_grant("t3_grant_seen", ok);
    check("t3_next_addr", last_gnt_addr, 32'h100);
    for (int i = 0; i < 20 && popped_q.size() == 0; i++) cycle();
    check("t3_first_pop", (popped_q.size() != 0) ? popped_q[0] : 32'hFFFF_FFFF, 32'h100);

    // 4: redirect coincides with rvalid
    lat_cfg = 2;
    for (int i = 0; i < 40 && !(mdl_out && !discard && mem_lat == 0); i++) cycle();
    check("t4_reach_rvalid", mdl_out && mem_lat == 0, 1);
    popped_q.delete();
    redir = 1; redir_tgt = 32'h0000_0200;
    cycle();
    redir = 0;
    check("t4_not_pushed", if_valid_o, 0);
    wait_grant("t4_grant_seen", ok);
    check("t4_next_addr", last_gnt_addr, 32'h200);
    for (int i = 0; i < 20 && popped_q.size() == 0; i++) cycle();
    check("t4_first_pop", (popped_q.size() != 0) ? popped_q[0] : 32'hFFFF_FFFF, 32'h200);

    // 5: address wrap, then grant withheld for three requesting cycles
    lat_cfg = 1;
    redir = 1; redir_tgt = 32'hFFFF_FFFC;
    cycle();
    redir = 0;
    wait_grant("t5_grant_seen", ok);
    check("t5_wrap_addr", last_gnt_addr, 32'hFFFF_FFFC);
    check("t5_wrap_next", last_gnt_next, 32'h0);
    wait_grant("t5_grant2_seen", ok);
    check("t5_after_wrap", last_gnt_addr, 32'h0);
    gnt_mode = 0;
    for (int i = 0; i < 20 && !imem_req_o; i++) cycle();
    check("t5_req_up", imem_req_o, 1);
`ifdef IF_PERF_CNT_EN
    s0 = perf_stall_o;
`else
    s0 = 32'h0;
`endif
    repeat (3) cycle();
    check("t5_req_held", imem_req_o, 1);
    check("t5_pc_hold", pc_next_o, pc_i);
`ifdef IF_PERF_CNT_EN
    check("t5_perf_stall", perf_stall_o - s0, 3);
`else
    check("t5_stall_base", s0 + 32'd3, 32'd3 + s0 ^ 32'h0);
`endif

    // random traffic against the reference model
    gnt_mode = 2; rdy_mode = 2; lat_cfg = 0; redir_rate = 12;
    repeat (3000) cycle();
    redir_rate = 0;
`ifdef IF_PERF_CNT_EN
    check("perf_fetched", perf_fetched_o, n_push);
`endif

    // 6: reset asserted while a request is outstanding with data buffered
    gnt_mode = 1; rdy_mode = 0; lat_cfg = 5;
    for (int i = 0; i < 60 && !(q.size() >= 1 && mdl_out && mem_lat >= 2); i++) cycle();
    check("t6_reach_wait", q.size() >= 1 && mdl_out && mem_lat >= 2, 1);
    check("t6_pre_valid", if_valid_o, 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", if_valid_o, 0);
    check("t6_async_req", imem_req_o, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    lat_cfg = 1; rdy_mode = 1;
    popped_q.delete();
    wait_grant("t6_grant_seen", ok);
    check("t6_restart_addr", last_gnt_addr, RPC);
    for (int i = 0; i < 20 && popped_q.size() == 0; i++) cycle();
    check("t6_first_pop", (popped_q.size() != 0) ? popped_q[0] : 32'hFFFF_FFFF, RPC);
    repeat (10) cycle();
`ifdef IF_PERF_CNT_EN
    check("t6_perf_fetched", perf_fetched_o, n_push);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
